// File: rtl/img_disp_ctrl_if.sv
// Bus bundle for the image display controller: image ROM read port,
// command port, result-buffer write port and status flags.
interface img_disp_ctrl_if #(
  parameter int DW = 8,
  parameter int XW = 3,
  parameter int YW = 3
);
  localparam int AW = XW + YW;

  logic [DW-1:0] IROM_Q;
  logic          IROM_EN;
  logic [AW-1:0] IROM_A;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic          IRB_RW;
  logic [DW-1:0] IRB_D;
  logic [AW-1:0] IRB_A;
  logic          busy;
  logic          done;

  // Controller side: reads the ROM, takes commands, writes the result buffer.
  modport master (
    input  IROM_Q, cmd, cmd_valid,
    output IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done
  );

  // Environment side: ROM, command source and result buffer.
  modport slave (
    output IROM_Q, cmd, cmd_valid,
    input  IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done
  );
endinterface

// File: rtl/img_disp_ctrl.sv
// Image display controller: loads a W x H image from ROM, applies 2x2
// window commands around a movable operation point, and writes the whole
// image out to the result buffer on request.
module img_disp_ctrl #(
  parameter int DW = 8,
  parameter int XW = 3,
  parameter int YW = 3
) (
  input  logic            clk,
  input  logic            reset,
  img_disp_ctrl_if.master bus
);
  localparam int AW = XW + YW;
  localparam int N  = 1 << AW;

  localparam logic [XW-1:0] X_MIN  = XW'(1);
  localparam logic [YW-1:0] Y_MIN  = YW'(1);
  localparam logic [XW-1:0] X_MAX  = XW'((1 << XW) - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'((1 << YW) - 1);
  localparam logic [XW-1:0] X_HOME = XW'(1 << (XW - 1));
  localparam logic [YW-1:0] Y_HOME = YW'(1 << (YW - 1));
  localparam logic [AW-1:0] A_LAST = AW'(N - 1);

  typedef enum logic [2:0] {LOAD, IDLE, EXEC, WRITE, FIN} state_e;

  typedef enum logic [3:0] {
    CMD_WRITE  = 4'd0,
    CMD_UP     = 4'd1,
    CMD_DOWN   = 4'd2,
    CMD_LEFT   = 4'd3,
    CMD_RIGHT  = 4'd4,
    CMD_AVG    = 4'd5,
    CMD_MIRX   = 4'd6,
    CMD_MIRY   = 4'd7,
    CMD_MAX    = 4'd8,
    CMD_MIN    = 4'd9,
    CMD_ROTCW  = 4'd10,
    CMD_ROTCCW = 4'd11,
    CMD_HOME   = 4'd12
  } cmd_e;

  state_e        state_q, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [XW-1:0] px_q, px_d;
  logic [YW-1:0] py_q, py_d;
  logic [AW-1:0] rom_a_q, rom_a_d;
  logic          rom_en_q, rom_en_d;
  logic          iss_done_q, iss_done_d;
  logic          cap_vld_q, cap_vld_d;
  logic [AW-1:0] cap_a_q, cap_a_d;
  logic          irb_rw_q, irb_rw_d;
  logic [AW-1:0] irb_a_q, irb_a_d;
  logic [DW-1:0] irb_d_q, irb_d_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] mem_q [N];
  logic [DW-1:0] mem_d [N];

  // Window geometry around the operation point; the point is always >= 1,
  // so the -1 neighbours never wrap.
  logic [XW-1:0] px_m1;
  logic [YW-1:0] py_m1;
  logic [AW-1:0] tl_a, tr_a, bl_a, br_a;
  logic [DW-1:0] tl, tr, bl, br;
  logic [DW+1:0] win_sum;
  logic [DW-1:0] win_avg, max_top, max_bot, win_max, min_top, min_bot, win_min;

  assign px_m1 = px_q - X_MIN;
  assign py_m1 = py_q - Y_MIN;
  assign tl_a  = {py_m1, px_m1};
  assign tr_a  = {py_m1, px_q};
  assign bl_a  = {py_q,  px_m1};
  assign br_a  = {py_q,  px_q};

  // All window sources come from the current buffer, so every update is
  // computed from the pre-update contents.
  assign tl = mem_q[tl_a];
  assign tr = mem_q[tr_a];
  assign bl = mem_q[bl_a];
  assign br = mem_q[br_a];

  assign win_sum = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};
  assign win_avg = win_sum[DW+1:2];
  assign max_top = (tl > tr) ? tl : tr;
  assign max_bot = (bl > br) ? bl : br;
  assign win_max = (max_top > max_bot) ? max_top : max_bot;
  assign min_top = (tl < tr) ? tl : tr;
  assign min_bot = (bl < br) ? bl : br;
  assign win_min = (min_top < min_bot) ? min_top : min_bot;

  logic          win_we;
  logic [DW-1:0] new_tl, new_tr, new_bl, new_br;

  // Next-state logic: ROM load, command decode, window update, write-out.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; an unassigned path in always_comb infers a latch.
    state_d    = state_q;
    cmd_d      = cmd_q;
    px_d       = px_q;
    py_d       = py_q;
    rom_a_d    = rom_a_q;
    rom_en_d   = rom_en_q;
    iss_done_d = iss_done_q;
    cap_vld_d  = 1'b0;
    cap_a_d    = cap_a_q;
    irb_rw_d   = irb_rw_q;
    irb_a_d    = irb_a_q;
    irb_d_d    = irb_d_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    win_we     = 1'b0;
    new_tl     = tl;
    new_tr     = tr;
    new_bl     = bl;
    new_br     = br;
    mem_d      = mem_q;

    unique case (state_q)
      LOAD: begin
        // ROM data arrives one cycle after its address: store it against
        // the address issued on the previous cycle.
        if (cap_vld_q) mem_d[cap_a_q] = bus.IROM_Q;
        if (!iss_done_q) begin
          cap_vld_d = 1'b1;
          cap_a_d   = rom_a_q;
          if (rom_a_q == A_LAST) iss_done_d = 1'b1;
          else                   rom_a_d    = rom_a_q + AW'(1);
        end
        if (cap_vld_q && cap_a_q == A_LAST) begin
          state_d  = IDLE;
          rom_en_d = 1'b1;
          busy_d   = 1'b0;
        end
      end

      IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d  = bus.cmd;
          busy_d = 1'b1;
          if (bus.cmd == CMD_WRITE) begin
            state_d  = WRITE;
            irb_rw_d = 1'b0;
            irb_a_d  = '0;
            irb_d_d  = mem_q[0];
          end else begin
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        case (cmd_q)
          CMD_UP:    if (py_q != Y_MIN) py_d = py_q - Y_MIN;
          CMD_DOWN:  if (py_q != Y_MAX) py_d = py_q + Y_MIN;
          CMD_LEFT:  if (px_q != X_MIN) px_d = px_q - X_MIN;
          CMD_RIGHT: if (px_q != X_MAX) px_d = px_q + X_MIN;
          CMD_AVG: begin
            win_we = 1'b1;
            new_tl = win_avg; new_tr = win_avg; new_bl = win_avg; new_br = win_avg;
          end
          CMD_MIRX: begin
            win_we = 1'b1;
            new_tl = bl; new_bl = tl; new_tr = br; new_br = tr;
          end
          CMD_MIRY: begin
            win_we = 1'b1;
            new_tl = tr; new_tr = tl; new_bl = br; new_br = bl;
          end
          CMD_MAX: begin
            win_we = 1'b1;
            new_tl = win_max; new_tr = win_max; new_bl = win_max; new_br = win_max;
          end
          CMD_MIN: begin
            win_we = 1'b1;
            new_tl = win_min; new_tr = win_min; new_bl = win_min; new_br = win_min;
          end
          CMD_ROTCW: begin
            win_we = 1'b1;
            new_tl = bl; new_tr = tl; new_br = tr; new_bl = br;
          end
          CMD_ROTCCW: begin
            win_we = 1'b1;
            new_tl = tr; new_tr = br; new_br = bl; new_bl = tl;
          end
          CMD_HOME: begin
            px_d = X_HOME;
            py_d = Y_HOME;
          end
          default: ; // codes 13-15 only spend the EXEC cycle
        endcase
        if (win_we) begin
          mem_d[tl_a] = new_tl;
          mem_d[tr_a] = new_tr;
          mem_d[bl_a] = new_bl;
          mem_d[br_a] = new_br;
        end
      end

      WRITE: begin
        if (irb_a_q == A_LAST) begin
          state_d  = FIN;
          irb_rw_d = 1'b1;
          done_d   = 1'b1;
        end else begin
          irb_a_d = irb_a_q + AW'(1);
          irb_d_d = mem_q[irb_a_q + AW'(1)];
        end
      end

      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = LOAD;
    endcase
  end

  // Controller state and registered outputs; reset restarts the ROM load.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= LOAD;
      cmd_q      <= '0;
      px_q       <= X_HOME;
      py_q       <= Y_HOME;
      rom_a_q    <= '0;
      rom_en_q   <= 1'b0;
      iss_done_q <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_a_q    <= '0;
      irb_rw_q   <= 1'b1;
      irb_a_q    <= '0;
      irb_d_q    <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      px_q       <= px_d;
      py_q       <= py_d;
      rom_a_q    <= rom_a_d;
      rom_en_q   <= rom_en_d;
      iss_done_q <= iss_done_d;
      cap_vld_q  <= cap_vld_d;
      cap_a_q    <= cap_a_d;
      irb_rw_q   <= irb_rw_d;
      irb_a_q    <= irb_a_d;
      irb_d_q    <= irb_d_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Image buffer storage.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; every entry is rewritten by LOAD
    // before anything can read it, so a reset would only cost logic.
    mem_q <= mem_d;
  end

  assign bus.IROM_EN = rom_en_q;
  assign bus.IROM_A  = rom_a_q;
  assign bus.IRB_RW  = irb_rw_q;
  assign bus.IRB_A   = irb_a_q;
  assign bus.IRB_D   = irb_d_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_img_disp_ctrl.sv
// Directed bench for img_disp_ctrl: two instances (8x8 and 16x4), each with
// a ROM holding ROM[i]=i and a monitor recording result-buffer writes.
module tb_img_disp_ctrl;
  logic clk;
  logic rst_a, rst_b;
  int   n_vec = 0;
  int   n_err = 0;

  img_disp_ctrl_if #(.DW(8), .XW(3), .YW(3)) ia ();
  img_disp_ctrl_if #(.DW(8), .XW(4), .YW(2)) ib ();

  img_disp_ctrl #(.DW(8), .XW(3), .YW(3)) dut_a (.clk(clk), .reset(rst_a), .bus(ia));
  img_disp_ctrl #(.DW(8), .XW(4), .YW(2)) dut_b (.clk(clk), .reset(rst_b), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROMs with one cycle of read latency, ROM[i] = i.
  always @(posedge clk) if (!ia.IROM_EN) ia.IROM_Q <= 8'(ia.IROM_A);
  always @(posedge clk) if (!ib.IROM_EN) ib.IROM_Q <= 8'(ib.IROM_A);

  // Result-buffer monitors, sampled on the falling edge.
  logic [7:0] rec_a [64];
  logic [7:0] rec_b [64];
  logic [7:0] exp_a [64];
  logic [7:0] exp_b [64];
  int wcnt_a = 0, wcnt_b = 0, ord_a = 0, ord_b = 0, done_a = 0, done_b = 0;

  always @(negedge clk) begin
    if (ia.IRB_RW === 1'b0) begin
      if (ia.IRB_A !== 6'(wcnt_a)) ord_a++;
      rec_a[ia.IRB_A] = ia.IRB_D;
      wcnt_a++;
    end
    if (ia.done === 1'b1) done_a++;
  end

  always @(negedge clk) begin
    if (ib.IRB_RW === 1'b0) begin
      if (ib.IRB_A !== 6'(wcnt_b)) ord_b++;
      rec_b[ib.IRB_A] = ib.IRB_D;
      wcnt_b++;
    end
    if (ib.done === 1'b1) done_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int dump_err_a();
    int e = 0;
    for (int i = 0; i < 64; i++) if (rec_a[i] !== exp_a[i]) e++;
    return e;
  endfunction

  function automatic int dump_err_b();
    int e = 0;
    for (int i = 0; i < 64; i++) if (rec_b[i] !== exp_b[i]) e++;
    return e;
  endfunction

  task automatic clear_a();
    for (int i = 0; i < 64; i++) rec_a[i] = 'x;
    wcnt_a = 0; ord_a = 0; done_a = 0;
  endtask

  task automatic clear_b();
    for (int i = 0; i < 64; i++) rec_b[i] = 'x;
    wcnt_b = 0; ord_b = 0; done_b = 0;
  endtask

  // Issue one command from a falling edge with busy low; returns the number
  // of edges after the accept edge until busy falls again.
  task automatic cmd_a(input logic [3:0] c, output int lat);
    ia.cmd = c;
    ia.cmd_valid = 1'b1;
    @(negedge clk);
    ia.cmd_valid = 1'b0;
    check("busy_on_accept_a", ia.busy, 1);
    lat = 0;
    while (ia.busy !== 1'b0 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("busy_off_a", ia.busy, 0);
  endtask

  task automatic cmd_b(input logic [3:0] c, output int lat);
    ib.cmd = c;
    ib.cmd_valid = 1'b1;
    @(negedge clk);
    ib.cmd_valid = 1'b0;
    check("busy_on_accept_b", ib.busy, 1);
    lat = 0;
    while (ib.busy !== 1'b0 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("busy_off_b", ib.busy, 0);
  endtask

  // Release reset on A and follow the load: IROM_A must step 0..63 with the
  // ROM enabled, and busy must fall on the 65th edge.
  task automatic load_a();
    int errs = 0;
    int fall = -1;
    rst_a = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c < 64 && (ia.IROM_A !== 6'(c) || ia.IROM_EN !== 1'b0)) errs++;
      if (ia.busy === 1'b0) begin
        fall = c;
        break;
      end
      @(negedge clk);
    end
    check("load_sweep_a", errs, 0);
    check("busy_fall_a", fall, 65);
    check("rom_off_a", ia.IROM_EN, 1);
  endtask

  int lat, rises, highs;
  logic prev;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ia.cmd = '0; ia.cmd_valid = 1'b0;
    ib.cmd = '0; ib.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_busy", ia.busy, 1);
    check("rst_done", ia.done, 0);
    check("rst_rom_en", ia.IROM_EN, 0);
    check("rst_rom_a", ia.IROM_A, 0);
    check("rst_irb_rw", ia.IRB_RW, 1);
    check("rst_irb_a", ia.IRB_A, 0);
    check("rst_irb_d", ia.IRB_D, 0);
    check("rst_px", dut_a.px_q, 4);
    check("rst_py", dut_a.py_q, 4);

    // Load, then a full write-out of the untouched image.
    load_a();
    for (int i = 0; i < 64; i++) exp_a[i] = 8'(i);
    clear_a();
    cmd_a(4'd0, lat);
    check("write_latency", lat, 65);
    check("write_count", wcnt_a, 64);
    check("write_order", ord_a, 0);
    check("write_data", dump_err_a(), 0);
    check("done_pulses", done_a, 1);

    // Average at (4,4): 27+28+35+36 = 126, floor(126/4) = 31.
    cmd_a(4'd5, lat);
    check("avg_latency", lat, 1);
    exp_a[27] = 8'd31; exp_a[28] = 8'd31; exp_a[35] = 8'd31; exp_a[36] = 8'd31;
    clear_a();
    cmd_a(4'd0, lat);
    check("avg_px35", rec_a[35], 31);
    check("avg_image", dump_err_a(), 0);
    check("avg_done", done_a, 1);

    // Left five times saturates px at 1; up five times brings py to 1 so the
    // rotation acts on the top-left corner window (pixels 0,1,8,9).
    repeat (5) cmd_a(4'd3, lat);
    check("left_sat_px", dut_a.px_q, 1);
    check("left_keeps_py", dut_a.py_q, 4);
    repeat (5) cmd_a(4'd1, lat);
    check("up_sat_py", dut_a.py_q, 1);
    cmd_a(4'd10, lat);
    exp_a[0] = 8'd8; exp_a[1] = 8'd0; exp_a[9] = 8'd1; exp_a[8] = 8'd9;
    clear_a();
    cmd_a(4'd0, lat);
    check("rotcw_px0", rec_a[0], 8);
    check("rotcw_px9", rec_a[9], 1);
    check("rotcw_image", dump_err_a(), 0);

    // A spare code still spends one EXEC cycle and changes nothing.
    cmd_a(4'd13, lat);
    check("noop_latency", lat, 1);
    check("noop_px", dut_a.px_q, 1);
    check("noop_py", dut_a.py_q, 1);

    // cmd_valid held with "down": one accept every other edge, py stops at 7.
    ia.cmd = 4'd2;
    ia.cmd_valid = 1'b1;
    rises = 0;
    highs = 0;
    prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ia.busy === 1'b1) begin
        highs++;
        if (!prev) rises++;
      end
      prev = ia.busy;
    end
    ia.cmd_valid = 1'b0;
    check("held_accepts", rises, 10);
    check("held_busy_cycles", highs, 10);
    check("down_sat_py", dut_a.py_q, 7);

    cmd_a(4'd12, lat);
    check("home_px", dut_a.px_q, 4);
    check("home_py", dut_a.py_q, 4);

    // Reset during write-out at IRB_A = 20.
    clear_a();
    ia.cmd = 4'd0;
    ia.cmd_valid = 1'b1;
    @(negedge clk);
    ia.cmd_valid = 1'b0;
    lat = 0;
    while (!(ia.IRB_RW === 1'b0 && ia.IRB_A === 6'd20) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("abort_reached_a20", ia.IRB_A, 20);
    rst_a = 1'b1;
    @(negedge clk);
    check("abort_irb_rw", ia.IRB_RW, 1);
    check("abort_busy", ia.busy, 1);
    check("abort_done", ia.done, 0);
    check("abort_rom_a", ia.IROM_A, 0);
    check("abort_rom_en", ia.IROM_EN, 0);
    @(negedge clk);
    load_a();
    check("abort_no_done", done_a, 0);
    check("abort_writes", wcnt_a, 21);

    // The reload restores the ROM image.
    for (int i = 0; i < 64; i++) exp_a[i] = 8'(i);
    clear_a();
    cmd_a(4'd0, lat);
    check("reload_image", dump_err_a(), 0);
    check("reload_done", done_a, 1);

    // 16x4 instance: home point is (8,2); mirror X swaps rows 1 and 2 in
    // columns 7 and 8, i.e. pixels 23<->39 and 24<->40.
    rst_b = 1'b0;
    lat = 0;
    while (ib.busy !== 1'b0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("busy_fall_b", lat, 65);
    cmd_b(4'd12, lat);
    check("b_home_px", dut_b.px_q, 8);
    check("b_home_py", dut_b.py_q, 2);
    cmd_b(4'd6, lat);
    for (int i = 0; i < 64; i++) exp_b[i] = 8'(i);
    exp_b[23] = 8'd39; exp_b[39] = 8'd23; exp_b[24] = 8'd40; exp_b[40] = 8'd24;
    clear_b();
    cmd_b(4'd0, lat);
    check("b_write_count", wcnt_b, 64);
    check("b_write_order", ord_b, 0);
    check("b_px23", rec_b[23], 39);
    check("b_px40", rec_b[40], 24);
    check("b_image", dump_err_b(), 0);
    check("b_done", done_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/img_disp_ctrl.md
IMG_DISP_CTRL -- requirements
Module: img_disp_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, meaning pixel data width in bits.
REQ-002 SHALL have parameter XW, default 3, meaning log2 of image width (W = 2^XW).
REQ-003 SHALL have parameter YW, default 3, meaning log2 of image height (H = 2^YW); AW = XW+YW and N = W*H.
REQ-004 SHALL have port clk, input, 1, system clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port IROM_Q, input, DW, image ROM read data, valid one cycle after IROM_A.
REQ-007 SHALL have port IROM_EN, output, 1, ROM enable, active-low.
REQ-008 SHALL have port IROM_A, output, AW, ROM address; pixel (x,y) is at y*W+x.
REQ-009 SHALL have port cmd, input, 4, command code.
REQ-010 SHALL have port cmd_valid, input, 1, command strobe.
REQ-011 SHALL have port IRB_RW, output, 1, result buffer write, 0 = write and 1 = idle.
REQ-012 SHALL have port IRB_D, output, DW, result buffer write data.
REQ-013 SHALL have port IRB_A, output, AW, result buffer address.
REQ-014 SHALL have port busy, output, 1, high while the block cannot accept a command.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at the end of each image write-out.

Function
REQ-016 SHALL implement states LOAD, IDLE, EXEC, WRITE and FIN, with LOAD entered on reset.
REQ-017 In LOAD, SHALL drive IROM_EN=0 and IROM_A = 0..N-1 on consecutive cycles, and capture IROM_Q into internal buffer entry IROM_A-1 one cycle later.
REQ-018 SHALL capture the last pixel N+1 cycles after reset release, then set IROM_EN=1 and busy=0 and enter IDLE.
REQ-019 SHALL hold the operation point (px,py), with px in 1..W-1 and py in 1..H-1; the window is pixels TL(px-1,py-1), TR(px,py-1), BL(px-1,py) and BR(px,py).
REQ-020 In IDLE, SHALL accept cmd when cmd_valid=1, raise busy on the next edge and enter EXEC (or WRITE for cmd 0).
REQ-021 SHALL ignore cmd_valid whenever busy=1.
REQ-022 EXEC SHALL last exactly one cycle, update the buffer or point at its end, then return to IDLE with busy=0.
REQ-023 cmd 1/2/3/4 SHALL be up/down/left/right: py-1, py+1, px-1, px+1, saturating at 1 and W-1/H-1 with no wrap.
REQ-024 cmd 5 SHALL write floor((TL+TR+BL+BR)/4) to all four window pixels, using a DW+2-bit sum with no overflow.
REQ-025 cmd 6 SHALL mirror X by swapping TL with BL and TR with BR.
REQ-026 cmd 7 SHALL mirror Y by swapping TL with TR and BL with BR.
REQ-027 cmd 8 SHALL write the maximum of the four window pixels to all four.
REQ-028 cmd 9 SHALL write the minimum of the four window pixels to all four.
REQ-029 cmd 10 SHALL rotate the window clockwise: new TL=BL, TR=TL, BR=TR, BL=BR.
REQ-030 cmd 11 SHALL rotate the window counter-clockwise: new TL=TR, TR=BR, BR=BL, BL=TL.
REQ-031 cmd 12 SHALL restore the point to (W/2,H/2) with image data unchanged.
REQ-032 cmd 13-15 SHALL be no-ops that still pass through EXEC (busy high for one cycle).
REQ-033 Every window update SHALL read all source values from the pre-update buffer contents.
REQ-034 In WRITE, SHALL drive IRB_RW=0, IRB_A = 0..N-1 and IRB_D = buffer[IRB_A] on N consecutive cycles.
REQ-035 After WRITE, SHALL enter FIN for one cycle with IRB_RW=1, done=1 and busy=1, then return to IDLE with busy=0.
REQ-036 SHALL preserve the buffer and point across a write, so further commands and writes remain legal.
REQ-037 done SHALL be 0 in every state except FIN.

Reset
REQ-038 While reset=1, SHALL hold busy=1, done=0, IROM_EN=0, IROM_A=0, IRB_RW=1, IRB_A=0, IRB_D=0, (px,py)=(W/2,H/2) and state LOAD.
REQ-039 A reset asserted in any state, including mid-LOAD or mid-WRITE, SHALL abort the operation and restart LOAD from address 0 after release.
REQ-040 Buffer contents SHALL NOT need a reset value.

Verification
REQ-041 Bench SHALL cover default params with ROM[i]=i, then reset release -> IROM_A sweeps 0..63, busy falls at cycle 65, then cmd 0 -> IRB writes 0..63 with matching data and done pulses once.
REQ-042 Bench SHALL cover ROM[i]=i, cmd 5 at (4,4) -> pixels 27,28,35,36 all equal 31 (sum 126, floor /4).
REQ-043 Bench SHALL cover cmd 3 issued five times from (4,4) -> px=1, then cmd 10 -> buffer[0]=8, [1]=0, [9]=1, [8]=9.
REQ-044 Bench SHALL cover cmd_valid held high with cmd 2 continuously -> exactly one accept per idle cycle and py saturating at 7.
REQ-045 Bench SHALL cover reset asserted at IRB_A=20 during WRITE -> done never pulses, IRB_RW=1, and LOAD restarts at IROM_A=0.
REQ-046 Bench SHALL cover XW=4 and YW=2 with cmd 12 then cmd 6 -> point (8,2), rows 1/2 columns 7/8 swapped, and 64 writes.
